// File: rtl/rgb2yuv_mac_sched.sv
// Sequencer for a time-shared RGB->YUV multiply-accumulate datapath.
// Accepts one pixel, then walks nine products and three stores before presenting YUV.
module rgb2yuv_mac_sched #(
  parameter int PIXELS_PER_FRAME = 16,
  parameter int IDX_W            = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pix_valid,
  output logic             pix_ready,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [15:0]      control,
  output logic             busy,
  output logic [IDX_W-1:0] pix_idx,
  output logic             frame_done
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] OUT  = 2'd2;

  localparam logic [3:0]       LAST_STEP = 4'd11;
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(PIXELS_PER_FRAME - 1);

  logic [1:0]       state_q, state_d;
  logic [3:0]       step_q, step_d;
  logic [IDX_W-1:0] pix_idx_q, pix_idx_d;
  logic             frame_done_q, frame_done_d;

  logic       fire;
  logic       handoff;
  logic [1:0] row;
  logic [1:0] phase;

  logic       in_load;
  logic [1:0] src_sel;
  logic [1:0] coef_row;
  logic       acc_clr;
  logic       acc_en;
  logic       y_load;
  logic       u_load;
  logic       v_load;
  logic       bias_en;

  // Held low during reset so nothing is accepted before the sequencer is live.
  always_comb begin
    pix_ready = rst_n & ((state_q == IDLE) | ((state_q == OUT) & out_ready));
    fire      = pix_valid & pix_ready;
    handoff   = (state_q == OUT) & out_ready;
    out_valid = (state_q == OUT);
    busy      = (state_q != IDLE);
  end

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    case (state_q)
      IDLE: begin
        if (fire) begin
          state_d = RUN;
          step_d  = 4'd0;
        end
      end
      RUN: begin
        if (step_q == LAST_STEP) begin
          state_d = OUT;
          step_d  = 4'd0;
        end else begin
          step_d = step_q + 4'd1;
        end
      end
      OUT: begin
        if (out_ready) begin
          state_d = fire ? RUN : IDLE;
          step_d  = 4'd0;
        end
      end
      default: begin
        state_d = IDLE;
        step_d  = 4'd0;
      end
    endcase
  end

  always_comb begin
    pix_idx_d    = pix_idx_q;
    frame_done_d = 1'b0;
    if (handoff) begin
      frame_done_d = (pix_idx_q == LAST_IDX);
      pix_idx_d    = (pix_idx_q == LAST_IDX) ? '0 : pix_idx_q + 1'b1;
    end
  end

  // Each output row takes four steps: R, G, B products, then the store.
  always_comb begin
    row      = step_q[3:2];
    phase    = step_q[1:0];
    in_load  = fire;
    src_sel  = 2'd0;
    coef_row = 2'd0;
    acc_clr  = 1'b0;
    acc_en   = 1'b0;
    y_load   = 1'b0;
    u_load   = 1'b0;
    v_load   = 1'b0;
    bias_en  = 1'b0;
    if (state_q == RUN) begin
      if (phase != 2'd3) begin
        src_sel  = phase;
        coef_row = row;
        acc_en   = 1'b1;
        acc_clr  = (phase == 2'd0);
      end else begin
        case (row)
          2'd0: y_load = 1'b1;
          2'd1: begin
            u_load  = 1'b1;
            bias_en = 1'b1;
          end
          2'd2: begin
            v_load  = 1'b1;
            bias_en = 1'b1;
          end
          default: ;
        endcase
      end
    end
    control = {5'b0, bias_en, v_load, u_load, y_load, acc_en, acc_clr,
               coef_row, src_sel, in_load};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      step_q       <= 4'd0;
      pix_idx_q    <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      step_q       <= step_d;
      pix_idx_q    <= pix_idx_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign pix_idx    = pix_idx_q;
  assign frame_done = frame_done_q;

endmodule
